// File: rtl/write_back_buffer_if.sv
// Bus bundle between the cache, the write-back buffer and lower memory.
// The slave side is the buffer. The master side is the cache plus the memory-ready input.
interface write_back_buffer_if #(
    parameter int TAG_WIDTH   = 4,
    parameter int VALUE_WIDTH = 32,
    parameter int DEPTH       = 4
);
    logic                         memwrite;
    logic [TAG_WIDTH-1:0]         tag_write;
    logic [VALUE_WIDTH-1:0]       value_write;
    logic                         full;
    logic                         empty;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;
    logic                         lookup_en;
    logic [TAG_WIDTH-1:0]         lookup_tag;
    logic                         lookup_hit;
    logic [VALUE_WIDTH-1:0]       lookup_value;
    logic                         mem_valid;
    logic [TAG_WIDTH-1:0]         mem_tag;
    logic [VALUE_WIDTH-1:0]       mem_value;
    logic                         mem_ready;

    modport master (
        output memwrite, tag_write, value_write, lookup_en, lookup_tag, mem_ready,
        input  full, empty, count, overflow, lookup_hit, lookup_value,
               mem_valid, mem_tag, mem_value
    );

    modport slave (
        input  memwrite, tag_write, value_write, lookup_en, lookup_tag, mem_ready,
        output full, empty, count, overflow, lookup_hit, lookup_value,
               mem_valid, mem_tag, mem_value
    );
endinterface

// File: rtl/write_back_buffer.sv
// Eviction queue between the LRU cache and lower memory.
// It drains queued entries in order, coalesces repeated evictions of a tag, and answers tag lookups.
module write_back_buffer #(
    parameter int TAG_WIDTH   = 4,
    parameter int VALUE_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic               clk,
    input  logic               rst,
    write_back_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_WIDTH-1:0]   tag_mem   [DEPTH];
    logic [VALUE_WIDTH-1:0] value_mem [DEPTH];
    logic [PTR_W-1:0]       head_reg;
    logic [PTR_W-1:0]       tail_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   overflow_reg;
    logic                   lookup_hit_reg;
    logic [VALUE_WIDTH-1:0] lookup_value_reg;

    logic [DEPTH-1:0]       nonhead_valid;
    logic [DEPTH-1:0]       coalesce_match;
    logic [DEPTH-1:0]       lookup_match;
    logic                   is_full;
    logic                   is_empty;
    logic                   push_append;
    logic                   push_drop;
    logic                   pop;
    logic                   head_lookup_hit;
    logic                   lookup_hit_next;
    logic [VALUE_WIDTH-1:0] lookup_value_next;

    // An entry is occupied when its distance from head is below count.
    // Distance 0 is the head itself. The head is never coalesced into, so mem_tag/mem_value stay stable.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset              = PTR_W'(gi) - head_reg;
            assign nonhead_valid[gi]   = (offset != '0) && (CNT_W'(offset) < count_reg);
            assign coalesce_match[gi]  = nonhead_valid[gi] && (tag_mem[gi] == bus.tag_write);
            assign lookup_match[gi]    = nonhead_valid[gi] && (tag_mem[gi] == bus.lookup_tag);
        end
    endgenerate

    assign is_full         = (count_reg == CNT_W'(DEPTH));
    assign is_empty        = (count_reg == '0);
    assign push_append     = bus.memwrite && !(|coalesce_match) && !is_full;
    assign push_drop       = bus.memwrite && !(|coalesce_match) && is_full;
    assign pop             = !is_empty && bus.mem_ready;
    assign head_lookup_hit = !is_empty && (tag_mem[head_reg] == bus.lookup_tag);

    // Lookup priority: the in-flight push first, then the non-head entries, then the head.
    always_comb begin
        lookup_hit_next   = 1'b0;
        lookup_value_next = '0;
        if (bus.memwrite && (bus.tag_write == bus.lookup_tag)) begin
            lookup_hit_next   = 1'b1;
            lookup_value_next = bus.value_write;
        end else if (|lookup_match) begin
            lookup_hit_next = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (lookup_match[i]) begin
                    lookup_value_next = value_mem[i];
                end
            end
        end else if (head_lookup_hit) begin
            lookup_hit_next   = 1'b1;
            lookup_value_next = value_mem[head_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i]   <= '0;
                value_mem[i] <= '0;
            end
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            overflow_reg     <= 1'b0;
            lookup_hit_reg   <= 1'b0;
            lookup_value_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.memwrite && coalesce_match[i]) begin
                    value_mem[i] <= bus.value_write;
                end
            end
            if (push_append) begin
                tag_mem[tail_reg]   <= bus.tag_write;
                value_mem[tail_reg] <= bus.value_write;
                tail_reg            <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push_append, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end
            if (bus.lookup_en) begin
                lookup_hit_reg   <= lookup_hit_next;
                lookup_value_reg <= lookup_value_next;
            end else begin
                lookup_hit_reg   <= 1'b0;
            end
        end
    end

    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.count        = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.lookup_hit   = lookup_hit_reg;
    assign bus.lookup_value = lookup_value_reg;
    assign bus.mem_valid    = !is_empty;
    assign bus.mem_tag      = tag_mem[head_reg];
    assign bus.mem_value    = value_mem[head_reg];
endmodule

// File: doc/write_back_buffer.md
# write_back_buffer

Queue between the LRU cache and lower memory: captures each dirty-line eviction the cache emits (memwrite, tag_write, value_write) and drains the entries in order to the lower memory over a valid/ready handshake. Lets the cache evict in one cycle without waiting on memory. Coalesces repeated evictions of the same tag. Answers tag lookups, so that a cache miss on a recently evicted tag takes the buffered data instead of stale memory.

## Interface
- TAG_WIDTH, 4, tag width; matches the cache.
- VALUE_WIDTH, 32, data width; matches the cache.
- DEPTH, 4, number of entries; power of two, ≥2.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- memwrite  in  1  push request from the cache (eviction of a dirty line).
- tag_write  in  TAG_WIDTH  tag of the evicted line.
- value_write  in  VALUE_WIDTH  data of the evicted line.
- full  out  1  count==DEPTH; the cache must stall evictions while this is high.
- empty  out  1  count==0.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- overflow  out  1  sticky; set when a push is dropped; cleared only by rst.
- lookup_en  in  1  lookup request.
- lookup_tag  in  TAG_WIDTH  tag to search for.
- lookup_hit  out  1  registered lookup result.
- lookup_value  out  VALUE_WIDTH  registered data for a hit; 0 on a miss.
- mem_valid  out  1  head entry presented to memory.
- mem_tag  out  TAG_WIDTH  tag of the head entry.
- mem_value  out  VALUE_WIDTH  data of the head entry.
- mem_ready  in  1  memory accepts the head entry.

## Operation
- Storage is a circular FIFO with head and tail pointers. Pointers wrap modulo DEPTH; count distinguishes full from empty.
- **Pop:** on an edge with mem_valid && mem_ready, head advances and count decrements.
- **Push** on memwrite, resolved in this order:
  - **Coalesce:** if a non-head valid entry has tag==tag_write, overwrite its value in place. Count is unchanged. This is allowed even when full.
  - The head entry is never overwritten. A push matching only the head is appended as a new entry.
  - **Append:** if count<DEPTH, write at tail and advance tail.
  - **Drop:** if count==DEPTH and there is no coalesce hit, the push is dropped and overflow←1. A pop in the same cycle does not rescue the push.
- At most one non-head entry matches any tag, so coalesce is unambiguous.
- **Push and pop in the same cycle:** both take effect; count is unchanged.
- **Lookup** (when lookup_en=1):
  - Search the current push first. If memwrite is high with a matching tag, forward value_write, even if that push is dropped.
  - Otherwise search the non-head entries, then the head.
  - A head entry that is being popped in the same cycle still reports a hit.
  - Result is registered into lookup_hit/lookup_value.
  - When lookup_en=0, lookup_hit←0 and lookup_value holds its previous value.
- **Reset:** head=tail=0, count=0, all storage cleared to 0, overflow=0, lookup_hit=0, lookup_value=0. Reset overrides any push, pop or lookup in the same cycle; a reset mid-drain discards all entries.

## Timing
- Reset values of outputs: full=0, empty=1, count=0, overflow=0, mem_valid=0, mem_tag=0, mem_value=0, lookup_hit=0, lookup_value=0.
- mem_valid = !empty. mem_tag/mem_value come from head storage.
- A push into an empty buffer at edge N gives mem_valid=1 after edge N.
- While mem_valid && !mem_ready, mem_tag/mem_value must stay stable. Guaranteed by the no-head-coalesce rule.
- full, empty and count update on the edge following the push/pop.
- Lookup latency: 1 cycle. Request sampled at edge N, result valid after edge N until edge N+1.
- Drain throughput: one entry per cycle with mem_ready held high.

## Test plan
- **Reset:** hold rst=1 for 2 cycles while memwrite=1 → count=0, empty=1, mem_valid=0, overflow=0 after release.
- **Fill and drain:** with mem_ready=0, push tags 5,6,7,8 → full=1, count=4, mem_tag=5. Then push tag 9 → overflow=1, count=4. Then mem_ready=1 → tags 5,6,7,8 drained in order over 4 cycles, then empty=1.
- **Coalesce:** push 5/A, 6/B, then 6/C with mem_ready=0 → count=2, and the drain gives 5/A, 6/C. Push 5/D while 5 is the head → appended, count=3, head stays 5/A.
- **Lookup:** with 7/0x1234 queued, lookup 7 → next cycle lookup_hit=1, lookup_value=0x1234. Lookup 3 → lookup_hit=0. Same-cycle push 3/0x55 with lookup 3 → hit, 0x55.
- **Simultaneous push and pop:** count=2, memwrite with a new tag plus mem_ready=1 → count stays 2 and FIFO order is preserved. Repeat across pointer wrap-around (more than 2×DEPTH pushes) → order intact.
- **Backpressure stability:** mem_ready toggled randomly while pushing new tags → mem_tag/mem_value never change while mem_valid && !mem_ready, and every pushed tag is drained exactly once, in order.
